lut_rr_scheduler: RTL

//  Round-robin scheduler sharing one combinational 256x24 neighbour-weight LUT (MRELBP ni weight ROM)

---
 rtl/mrelbp_pkg.sv | 9 +
 rtl/rr_arbiter.sv | 33 +++
 rtl/lut_rr_scheduler.sv | 93 +++++++++
 3 files changed

// File: rtl/mrelbp_pkg.sv
// Shared MRELBP constants and types for the neighbour-weight LUT path.
package mrelbp_pkg;
  localparam int LUT_ADDR_W = 8;
  localparam int LUT_DATA_W = 24;
  localparam int NUM_NI     = 8;

  typedef logic [LUT_ADDR_W-1:0] lut_addr_t;
  typedef logic [LUT_DATA_W-1:0] lut_data_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: lowest set request at or above ptr_i, wrapping,
// found by scanning a doubled request vector with everything below ptr_i masked off.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] gnt_idx_o
);
  logic [2*N-1:0] dreq;
  logic [2*N-1:0] below;
  logic [2*N-1:0] masked;
  logic           found;

  assign dreq   = {req_i, req_i};
  assign below  = ((2*N)'(1) << ptr_i) - (2*N)'(1);
  assign masked = dreq & ~below;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    for (int i = 0; i < 2*N; i++) begin
      if (!found && masked[i]) begin
        found          = 1'b1;
        gnt_idx_o      = IW'(i % N);
        gnt_o[i % N]   = 1'b1;
      end
    end
  end
endmodule

// File: rtl/lut_rr_scheduler.sv
// Round-robin scheduler sharing one combinational weight LUT between NUM_REQ lanes.
// Two-stage pipe: registered LUT address, then captured weight tagged with lane id.
module lut_rr_scheduler
  import mrelbp_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int ADDR_W  = LUT_ADDR_W,
  parameter  int DATA_W  = LUT_DATA_W,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [NUM_REQ-1:0]        i_req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] i_req_addr,
  output logic [NUM_REQ-1:0]        o_req_ready,
  output logic [ADDR_W-1:0]         o_lut_addr,
  input  logic [DATA_W-1:0]         i_lut_dout,
  output logic                      o_rsp_valid,
  output logic [ID_W-1:0]           o_rsp_id,
  output logic [DATA_W-1:0]         o_rsp_data,
  output logic                      o_busy
);
  // Handshake: lane r is accepted on a rising edge where i_req_valid[r] & o_req_ready[r];
  // ready is one-hot, never depends on the response side, and the response has no backpressure.
  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    gnt_idx;
  logic               accept;

  logic [ID_W-1:0]   ptr_q,      ptr_d;
  logic              s1_v_q,     s1_v_d;
  logic [ID_W-1:0]   s1_id_q,    s1_id_d;
  logic [ADDR_W-1:0] lut_addr_q, lut_addr_d;
  logic              rsp_v_q,    rsp_v_d;
  logic [ID_W-1:0]   rsp_id_q,   rsp_id_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req_i     (i_req_valid),
    .ptr_i     (ptr_q),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx)
  );

  assign o_req_ready = i_rst ? '0 : gnt;
  assign accept      = |o_req_ready;

  always_comb begin
    ptr_d      = ptr_q;
    s1_v_d     = 1'b0;
    s1_id_d    = s1_id_q;
    lut_addr_d = lut_addr_q;
    rsp_v_d    = s1_v_q;
    rsp_id_d   = rsp_id_q;
    rsp_data_d = rsp_data_q;
    if (accept) begin
      ptr_d      = (gnt_idx == ID_W'(NUM_REQ-1)) ? '0 : gnt_idx + ID_W'(1);
      s1_v_d     = 1'b1;
      s1_id_d    = gnt_idx;
      lut_addr_d = i_req_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
    end
    // LUT output is combinational from the registered address, so capture it one stage later
    if (s1_v_q) begin
      rsp_id_d   = s1_id_q;
      rsp_data_d = i_lut_dout;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ptr_q      <= '0;
      s1_v_q     <= 1'b0;
      s1_id_q    <= '0;
      lut_addr_q <= '0;
      rsp_v_q    <= 1'b0;
      rsp_id_q   <= '0;
      rsp_data_q <= '0;
    end else begin
      ptr_q      <= ptr_d;
      s1_v_q     <= s1_v_d;
      s1_id_q    <= s1_id_d;
      lut_addr_q <= lut_addr_d;
      rsp_v_q    <= rsp_v_d;
      rsp_id_q   <= rsp_id_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  assign o_lut_addr  = lut_addr_q;
  assign o_rsp_valid = rsp_v_q;
  assign o_rsp_id    = rsp_id_q;
  assign o_rsp_data  = rsp_data_q;
  assign o_busy      = s1_v_q | rsp_v_q;
endmodule
